// File: rtl/vector_norm_pkg.sv
// vector_norm_pkg: shared FSM state type and width helpers for vector_norm.
// Optional feature macro: VECTOR_NORM_SQRT_EN (adds the SQRT state).
package vector_norm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
`ifdef VECTOR_NORM_SQRT_EN
    SQRT   = 2'd2,
`endif
    OUTPUT = 2'd3
  } state_t;

  // Accumulator width: a full square plus growth for summing DIM terms.
  function automatic int acc_width(input int width, input int dim);
    return 2 * width + ((dim > 1) ? $clog2(dim) : 0);
  endfunction

  // Square-root iterations: two radicand bits are consumed per cycle.
  function automatic int sqrt_cycles(input int acc_w);
    return (acc_w + 1) / 2;
  endfunction

endpackage

// File: rtl/vector_norm_if.sv
// vector_norm_if: upstream (nd/us_rfd/vec) and downstream (rdy/ds_rfd/length)
// handshake bundle. The slave modport is the vector_norm side.
interface vector_norm_if
  import vector_norm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIM   = 3
);
  localparam int ACC_W = acc_width(WIDTH, DIM);

  logic                   nd;
  logic                   us_rfd;
  logic [DIM*WIDTH-1:0]   vec;
  logic                   ds_rfd;
  logic                   rdy;
  logic [ACC_W-1:0]       length;

  modport master (
    output nd, vec, ds_rfd,
    input  us_rfd, rdy, length
  );

  modport slave (
    input  nd, vec, ds_rfd,
    output us_rfd, rdy, length
  );

endinterface

// File: rtl/vector_norm_isqrt_seq.sv
// isqrt_seq: iterative restoring integer square root, two radicand bits per
// cycle. start_i loads the radicand; done_o is high during the cycle whose
// closing edge produces the final root bit, so root_o is valid right after.
// Used by vector_norm only when VECTOR_NORM_SQRT_EN is defined.
module isqrt_seq
  import vector_norm_pkg::*;
#(
  parameter int ACC_W = 34
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [ACC_W-1:0]              rad_i,
  output logic                          done_o,
  output logic [sqrt_cycles(ACC_W)-1:0] root_o
);
  localparam int S      = sqrt_cycles(ACC_W);
  localparam int RAD_W  = 2 * S;
  // remainder never exceeds 2*root < 2^(S+1); two extra bits hold the shift-in
  localparam int REM_W  = S + 3;
  localparam int ITER_W = (S > 1) ? $clog2(S) : 1;

  logic              busy_q, busy_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [RAD_W-1:0]  rad_q, rad_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [S-1:0]      root_q, root_d;

  logic [REM_W-1:0]  rem_sh;
  logic [REM_W-1:0]  trial;
  logic              fits;

  assign rem_sh = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
  assign trial  = {1'b0, root_q, 2'b01};
  assign fits   = (rem_sh >= trial);
  assign done_o = busy_q && (iter_q == ITER_W'(S - 1));
  assign root_o = root_q;

  // Next-state: load on start, otherwise one restoring step per busy cycle.
  always_comb begin
    busy_d = busy_q;
    iter_d = iter_q;
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    if (start_i) begin
      busy_d = 1'b1;
      iter_d = '0;
      rad_d  = RAD_W'(rad_i);
      rem_d  = '0;
      root_d = '0;
    end else if (busy_q) begin
      rad_d  = rad_q << 2;
      rem_d  = fits ? (rem_sh - trial) : rem_sh;
      root_d = {root_q[S-2:0], fits};
      iter_d = iter_q + ITER_W'(1);
      if (done_o) busy_d = 1'b0;
    end
  end

  // Datapath and control registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      iter_q <= '0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
    end else begin
      busy_q <= busy_d;
      iter_q <= iter_d;
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
    end
  end

endmodule

// File: rtl/vector_norm.sv
// vector_norm: sum of squares of DIM signed components using one multiplier,
// one component per cycle. With VECTOR_NORM_SQRT_EN defined the result is
// floor(sqrt(sum)) from isqrt_seq; otherwise the raw sum is delivered.
module vector_norm
  import vector_norm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIM   = 3
) (
  input  logic          clk,
  input  logic          rst,
  vector_norm_if.slave  bus
);
  localparam int ACC_W = acc_width(WIDTH, DIM);
  localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;

  state_t               state_q, state_d;
  logic [DIM*WIDTH-1:0] vec_q, vec_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d;

  logic                     us_rfd;
  logic                     accept;
  logic                     last;
  logic signed [WIDTH-1:0]  comp;
  logic signed [2*WIDTH-1:0] sq;
  logic [ACC_W-1:0]         sq_ext;
  logic [ACC_W-1:0]         result;

  assign us_rfd = (state_q == IDLE) || ((state_q == OUTPUT) && bus.ds_rfd);
  assign accept = bus.nd && us_rfd;
  assign last   = (cnt_q == CNT_W'(DIM - 1));

  // The square of -2^(WIDTH-1) is 2^(2*WIDTH-2): always non-negative in sq.
  assign comp   = $signed(vec_q[cnt_q*WIDTH +: WIDTH]);
  assign sq     = comp * comp;
  assign sq_ext = ACC_W'($unsigned(sq));

`ifdef VECTOR_NORM_SQRT_EN
  localparam int S = sqrt_cycles(ACC_W);
  logic         sq_start;
  logic         sq_done;
  logic [S-1:0] root;

  // The final accumulator value (acc_d) is handed over on the last MAC edge.
  assign sq_start = (state_q == MAC) && last;

  isqrt_seq #(.ACC_W(ACC_W)) u_isqrt (
    .clk     (clk),
    .rst     (rst),
    .start_i (sq_start),
    .rad_i   (acc_d),
    .done_o  (sq_done),
    .root_o  (root)
  );

  assign result = {{(ACC_W-S){1'b0}}, root};
`else
  assign result = acc_q;
`endif

  assign bus.us_rfd = us_rfd;
  assign bus.rdy    = (state_q == OUTPUT);
  assign bus.length = (state_q == OUTPUT) ? result : '0;

  // Next-state logic; an accept out of OUTPUT goes straight back to MAC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = MAC;
`ifdef VECTOR_NORM_SQRT_EN
      MAC:    if (last) state_d = SQRT;
      SQRT:   if (sq_done) state_d = OUTPUT;
`else
      MAC:    if (last) state_d = OUTPUT;
`endif
      OUTPUT: if (bus.ds_rfd) state_d = bus.nd ? MAC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture, component counter and accumulator updates.
  always_comb begin
    vec_d = vec_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (accept) begin
      vec_d = bus.vec;
      cnt_d = '0;
      acc_d = '0;
    end else if (state_q == MAC) begin
      acc_d = acc_q + sq_ext;
      cnt_d = last ? '0 : (cnt_q + CNT_W'(1));
    end
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_vector_norm.sv
// tb_vector_norm: directed and random vectors on a DIM=3 and a DIM=1 instance,
// compared against an arithmetic model of the norm and its latency.
module tb_vector_norm;
  localparam int W    = 16;
  localparam int D3   = 3;
  localparam int D1   = 1;
  localparam int ACC3 = 2 * W + 2;   // $clog2(3) = 2
  localparam int ACC1 = 2 * W;       // $clog2(1) taken as 0
`ifdef VECTOR_NORM_SQRT_EN
  localparam int LAT3 = D3 + (ACC3 + 1) / 2;
  localparam int LAT1 = D1 + (ACC1 + 1) / 2;
`else
  localparam int LAT3 = D3;
  localparam int LAT1 = D1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_norm_if #(.WIDTH(W), .DIM(D3)) if3 ();
  vector_norm_if #(.WIDTH(W), .DIM(D1)) if1 ();

  vector_norm #(.WIDTH(W), .DIM(D3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  vector_norm #(.WIDTH(W), .DIM(D1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum of squares, or its floor square root when enabled.
  function automatic longint ref_norm(input longint s);
`ifdef VECTOR_NORM_SQRT_EN
    longint lo, hi, mid;
    lo = 0;
    hi = 64'd4294967296;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= s) lo = mid;
      else hi = mid - 1;
    end
    return lo;
`else
    return s;
`endif
  endfunction

  function automatic longint sumsq3(input int c0, input int c1, input int c2);
    return longint'(c0) * c0 + longint'(c1) * c1 + longint'(c2) * c2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for rdy on the DIM=3 instance; returns edges since the accept.
  task automatic wait_rdy3(output int cyc);
    cyc = 0;
    while (if3.rdy !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run3(input int c0, input int c1, input int c2, input string tag);
    longint exp;
    int cyc;
    exp = ref_norm(sumsq3(c0, c1, c2));
    chk({tag, " us_rfd"}, if3.us_rfd, 1);
    if3.vec = {W'(c2), W'(c1), W'(c0)};
    if3.nd  = 1'b1;
    tick();
    if3.nd = 1'b0;
    chk({tag, " length idle"}, if3.length, 0);
    wait_rdy3(cyc);
    chk({tag, " latency"}, cyc, LAT3);
    chk({tag, " length"}, if3.length, exp);
    tick();
    chk({tag, " drained"}, if3.rdy, 0);
  endtask

  task automatic run1(input int c0, input string tag);
    longint exp;
    int cyc;
    exp = ref_norm(longint'(c0) * c0);
    if1.vec = W'(c0);
    if1.nd  = 1'b1;
    tick();
    if1.nd = 1'b0;
    cyc = 0;
    while (if1.rdy !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
    chk({tag, " latency"}, cyc, LAT1);
    chk({tag, " length"}, if1.length, exp);
    tick();
    chk({tag, " drained"}, if1.rdy, 0);
  endtask

  initial begin
    int cyc;
    int r0, r1, r2;
    bit seen;
    longint expa, expb;

    if3.nd = 1'b0; if3.ds_rfd = 1'b1; if3.vec = '0;
    if1.nd = 1'b0; if1.ds_rfd = 1'b1; if1.vec = '0;

    // Reset values
    #2 rst = 1'b0;
    tick();
    tick();
    chk("rst rdy3", if3.rdy, 0);
    chk("rst length3", if3.length, 0);
    chk("rst us_rfd3", if3.us_rfd, 1);
    chk("rst rdy1", if1.rdy, 0);
    chk("rst length1", if1.length, 0);
    rst = 1'b1;

    // First accept on the first edge after reset release
    run3(3, 4, 12, "vec_3_4_12");
    run3(-32768, -32768, -32768, "vec_min");
    run3(0, 0, 0, "vec_zero");
    run3(32767, -32768, 1, "vec_mixed");
    for (int i = 0; i < 8; i++) begin
      r0 = $signed(W'($urandom));
      r1 = $signed(W'($urandom));
      r2 = $signed(W'($urandom));
      run3(r0, r1, r2, "vec_rand");
    end

    // Backpressure then simultaneous transfer + accept
    expa = ref_norm(sumsq3(5, -7, 9));
    expb = ref_norm(sumsq3(2, 3, 6));
    if3.ds_rfd = 1'b0;
    if3.vec = {W'(9), W'(-7), W'(5)};
    if3.nd  = 1'b1;
    tick();
    if3.nd = 1'b0;
    wait_rdy3(cyc);
    chk("bp latency", cyc, LAT3);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp rdy held", if3.rdy, 1);
      chk("bp length held", if3.length, expa);
      chk("bp us_rfd low", if3.us_rfd, 0);
    end
    if3.ds_rfd = 1'b1;
    if3.vec = {W'(6), W'(3), W'(2)};
    if3.nd  = 1'b1;
    #1;
    chk("bp us_rfd comb", if3.us_rfd, 1);
    tick();
    if3.nd = 1'b0;
    chk("b2b rdy after xfer", if3.rdy, 0);
    wait_rdy3(cyc);
    chk("b2b latency", cyc, LAT3);
    chk("b2b length", if3.length, expb);
    tick();

    // Reset mid-MAC
    if3.vec = {W'(-32768), W'(-32768), W'(-32768)};
    if3.nd  = 1'b1;
    tick();
    if3.nd = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort mac rdy", if3.rdy, 0);
    chk("abort mac length", if3.length, 0);
    chk("abort mac us_rfd", if3.us_rfd, 1);
    tick();
    rst = 1'b1;

    // Reset mid-OUTPUT under backpressure
    if3.ds_rfd = 1'b0;
    if3.vec = {W'(100), W'(200), W'(300)};
    if3.nd  = 1'b1;
    tick();
    if3.nd = 1'b0;
    wait_rdy3(cyc);
    chk("abort out latency", cyc, LAT3);
    rst = 1'b0;
    #1;
    chk("abort out rdy", if3.rdy, 0);
    chk("abort out length", if3.length, 0);
    tick();
    rst = 1'b1;
    if3.ds_rfd = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < LAT3 + 3; k++) begin
      tick();
      if (if3.rdy === 1'b1) seen = 1'b1;
    end
    chk("no result after abort", seen, 0);
    run3(1, 1, 1, "vec_1_1_1");

    // DIM=1 instance
    run1(-5, "dim1_neg5");
    run1(0, "dim1_zero");
    run1(-32768, "dim1_min");
    run1(int'($signed(W'($urandom))), "dim1_rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_norm.md
VECTOR_NORM -- requirements
Module: vector_norm

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each signed two's-complement component; legal range is 2 or more.
REQ-002 Parameter DIM, default 3: number of components per vector; legal range is 1 or more.
REQ-003 Derived constant ACC_W SHALL equal 2*WIDTH + $clog2(DIM), with $clog2(1) taken as 0.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 rst  input  1: asynchronous, active-low reset.
REQ-006 nd  input  1: upstream new-data strobe.
REQ-007 us_rfd  output  1: upstream ready-for-data.
REQ-008 vec  input  DIM*WIDTH: packed components; component i occupies bits [i*WIDTH +: WIDTH].
REQ-009 ds_rfd  input  1: downstream ready-for-data.
REQ-010 rdy  output  1: result valid.
REQ-011 length  output  ACC_W: unsigned result.

Function
REQ-012 States SHALL be IDLE, MAC, SQRT and OUTPUT; SQRT exists only when VECTOR_NORM_SQRT_EN is defined.
REQ-013 Accept: a vector is accepted on an edge where nd && us_rfd; vec is registered on that edge and the state moves to MAC.
REQ-014 nd while us_rfd is low SHALL be ignored, with no queuing.
REQ-015 MAC: exactly one component is squared and accumulated per cycle, component 0 first, using a single multiplier; after DIM edges the state leaves MAC.
REQ-016 The accumulator is ACC_W bits, unsigned, and cleared on accept.
REQ-017 No overflow is possible: a -2^(WIDTH-1) component squares to 2^(2*WIDTH-2) exactly.
REQ-018 Without VECTOR_NORM_SQRT_EN: MAC->OUTPUT; latency is DIM cycles from the accepting edge to rdy high.
REQ-019 With VECTOR_NORM_SQRT_EN: MAC->SQRT->OUTPUT; SQRT lasts S = ceil(ACC_W/2) cycles; latency is DIM+S cycles.
REQ-020 rdy SHALL be high exactly in OUTPUT.
REQ-021 length SHALL equal the result while rdy is high and SHALL be 0 otherwise.
REQ-022 length SHALL be stable while rdy && !ds_rfd, for unbounded backpressure.
REQ-023 Output transfer occurs on an edge where rdy && ds_rfd; the state then returns to IDLE.
REQ-024 us_rfd = (state==IDLE) || (state==OUTPUT && ds_rfd); this is a combinational path from ds_rfd.
REQ-025 Simultaneous transfer and accept in OUTPUT: the result is delivered and the new vector is captured on the same edge; the state goes directly to MAC with no bubble.
REQ-026 DIM=1: MAC lasts one cycle.
REQ-027 A zero vector SHALL yield length 0 in both configurations.

Reset
REQ-028 While rst is low: state=IDLE, accumulator=0, captured vector=0, component counter=0, SQRT datapath=0.
REQ-029 While rst is low: rdy=0, length=0, us_rfd=1.
REQ-030 Reset asserted mid-MAC, mid-SQRT or mid-OUTPUT SHALL abort the operation immediately; no result is ever delivered for an aborted vector.
REQ-031 The first accept is possible on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro VECTOR_NORM_SQRT_EN: when defined, length = floor(sqrt(sum of squares)), zero-extended to ACC_W (upper ACC_W-S bits are 0).
REQ-033 When VECTOR_NORM_SQRT_EN is undefined, length = sum of squares, and no square-root logic or SQRT state is synthesised.

Structure
REQ-034 Package vector_norm_pkg SHALL hold the state enum typedef and the acc_width(WIDTH,DIM) and sqrt_cycles(ACC_W) constant functions.
REQ-035 Sub-module isqrt_seq: iterative restoring integer square root, 2 radicand bits per cycle, with start/done handshake, parametrised by ACC_W; instantiated only under VECTOR_NORM_SQRT_EN.

Verification
REQ-036 WIDTH=16, DIM=3, no sqrt; vec=(3,4,12), ds_rfd=1 -> rdy high 3 cycles after accept, length=169 for one cycle.
REQ-037 Same vec with VECTOR_NORM_SQRT_EN -> rdy after 3+17=20 cycles, length=13.
REQ-038 vec=(-32768,-32768,-32768) -> length=3221225472 without sqrt, 56755 with sqrt.
REQ-039 ds_rfd held low for 5 cycles in OUTPUT -> rdy and length held constant, us_rfd=0; ds_rfd=1 with nd=1 -> result transferred and next vector accepted on the same edge.
REQ-040 rst pulsed low mid-MAC -> rdy=0 and length=0 immediately; the next vector (1,1,1) yields 3 with no residue from the aborted vector.
REQ-041 DIM=1, vec=(-5) -> rdy 1 cycle after accept, length=25; zero vector -> length=0.
